// File: rtl/cbfp_pkg.sv
// Shared widths, bank-state encoding and the normalize helper for the stage-0 CBFP block.
// Widths are fixed by the stage-0 datapath; the block length is tied to the mag_en window.
package cbfp_pkg;

    localparam int unsigned IN_W  = 23;
    localparam int unsigned OUT_W = 11;
    localparam int unsigned BLK   = 32;
    localparam int unsigned LSC_W = 5;

    typedef logic [LSC_W-1:0] lsc_t;

    typedef logic [1:0] bank_state_e;
    localparam bank_state_e BANK_FREE  = 2'd0;
    localparam bank_state_e BANK_FILL  = 2'd1;
    localparam bank_state_e BANK_FULL  = 2'd2;
    localparam bank_state_e BANK_DRAIN = 2'd3;

    // (x <<< m) >>> (IN_W-OUT_W): keep the top OUT_W bits of the left-shifted sample.
    function automatic logic [OUT_W-1:0] normalize(input logic [IN_W-1:0] x, input lsc_t m);
        logic [IN_W-1:0] s;
        s = x << m;
        return s[IN_W-1 -: OUT_W];
    endfunction

endpackage

// File: rtl/cbfp_lsc.sv
// Combinational leading-sign counter: number of bits below the MSB that equal the MSB.
module cbfp_lsc
    import cbfp_pkg::*;
(
    input  logic [IN_W-1:0] x,
    output lsc_t            lsc
);

    logic run;

    always_comb begin
        lsc = '0;
        run = 1'b1;
        for (int i = IN_W - 2; i >= 0; i--) begin
            if (run && (x[i] == x[IN_W-1])) begin
                lsc = lsc + lsc_t'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cbfp0_mag_norm.sv
// Stage-0 CBFP magnitude detect + normalize: ping-pong captures 32-sample blocks, tracks the
// block minimum leading-sign count and replays each block shifted by it.
module cbfp0_mag_norm
    import cbfp_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             mag_en,
    input  logic [IN_W-1:0]  din_re,
    input  logic [IN_W-1:0]  din_im,
    output logic             dout_valid,
    output logic [OUT_W-1:0] dout_re,
    output logic [OUT_W-1:0] dout_im,
    output logic [4:0]       dout_idx,
    output lsc_t             shift_amt
);

    localparam int unsigned          IDX_W    = $clog2(BLK);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BLK - 1);
    localparam lsc_t                 LSC_MAX  = lsc_t'(IN_W - 1);

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_RUN  = 1'b1;

    logic [IN_W-1:0]  mem_re [2][BLK];
    logic [IN_W-1:0]  mem_im [2][BLK];

    logic             wr_bank_q;
    logic [IDX_W-1:0] wr_cnt_q;
    lsc_t             min_q;
    lsc_t             m_q [2];
    bank_state_e      bank_q [2];
    bank_state_e      bank_d [2];

    logic [0:0]       rd_state_q, rd_state_d;
    logic             rd_bank_q, rd_bank_d;
    logic             rd_next_q, rd_next_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;

    lsc_t             lsc_re, lsc_im;
    lsc_t             min_base, min_next;
    logic             wr_last;
    logic             rd_last;
    logic             start_ok;

    cbfp_lsc u_lsc_re (
        .x   (din_re),
        .lsc (lsc_re)
    );

    cbfp_lsc u_lsc_im (
        .x   (din_im),
        .lsc (lsc_im)
    );

    // Running minimum restarts at the largest possible LSC on the first sample of a block.
    always_comb begin
        min_base = (wr_cnt_q == '0) ? LSC_MAX : min_q;
        min_next = min_base;
        if (lsc_re < min_next) min_next = lsc_re;
        if (lsc_im < min_next) min_next = lsc_im;
    end

    assign wr_last  = mag_en && (wr_cnt_q == LAST_IDX);
    assign rd_last  = (rd_state_q == RD_RUN) && (rd_idx_q == LAST_IDX);
    assign start_ok = (bank_q[rd_next_q] == BANK_FULL);

    always_comb begin
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        rd_next_d  = rd_next_q;
        rd_idx_d   = rd_idx_q;
        bank_d[0]  = bank_q[0];
        bank_d[1]  = bank_q[1];

        unique case (rd_state_q)
            RD_IDLE: begin
                if (start_ok) begin
                    rd_state_d        = RD_RUN;
                    rd_bank_d         = rd_next_q;
                    rd_next_d         = ~rd_next_q;
                    rd_idx_d          = '0;
                    bank_d[rd_next_q] = BANK_DRAIN;
                end
            end
            RD_RUN: begin
                rd_idx_d = rd_idx_q + IDX_W'(1);
                if (rd_last) begin
                    // A bank that already took its first new write stays in FILL.
                    if (bank_q[rd_bank_q] == BANK_DRAIN) bank_d[rd_bank_q] = BANK_FREE;
                    if (start_ok) begin
                        rd_bank_d         = rd_next_q;
                        rd_next_d         = ~rd_next_q;
                        rd_idx_d          = '0;
                        bank_d[rd_next_q] = BANK_DRAIN;
                    end else begin
                        rd_state_d = RD_IDLE;
                        rd_idx_d   = '0;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        // Write-side transitions win over the drain release in the same cycle.
        if (mag_en) begin
            if (wr_cnt_q == '0) bank_d[wr_bank_q] = BANK_FILL;
            if (wr_last)        bank_d[wr_bank_q] = BANK_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (mag_en) begin
            mem_re[wr_bank_q][wr_cnt_q] <= din_re;
            mem_im[wr_bank_q][wr_cnt_q] <= din_im;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            min_q      <= LSC_MAX;
            m_q[0]     <= '0;
            m_q[1]     <= '0;
            bank_q[0]  <= BANK_FREE;
            bank_q[1]  <= BANK_FREE;
            rd_state_q <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            rd_next_q  <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            bank_q[0]  <= bank_d[0];
            bank_q[1]  <= bank_d[1];
            rd_state_q <= rd_state_d;
            rd_bank_q  <= rd_bank_d;
            rd_next_q  <= rd_next_d;
            rd_idx_q   <= rd_idx_d;
            if (mag_en) begin
                min_q    <= min_next;
                wr_cnt_q <= wr_cnt_q + IDX_W'(1);
                if (wr_last) begin
                    m_q[wr_bank_q] <= min_next;
                    wr_bank_q      <= ~wr_bank_q;
                    wr_cnt_q       <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            dout_valid <= 1'b0;
            dout_re    <= '0;
            dout_im    <= '0;
            dout_idx   <= '0;
            shift_amt  <= '0;
        end else begin
            dout_valid <= (rd_state_q == RD_RUN);
            if (rd_state_q == RD_RUN) begin
                dout_re   <= normalize(mem_re[rd_bank_q][rd_idx_q], m_q[rd_bank_q]);
                dout_im   <= normalize(mem_im[rd_bank_q][rd_idx_q], m_q[rd_bank_q]);
                dout_idx  <= rd_idx_q;
                shift_amt <= m_q[rd_bank_q];
            end
        end
    end

endmodule

// File: tb/tb_cbfp0_mag_norm.sv
// Randomized bench for cbfp0_mag_norm against an arithmetic block-floating-point model.
module tb_cbfp0_mag_norm;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mag_en;
    logic [22:0] din_re, din_im;
    logic        dout_valid;
    logic [10:0] dout_re, dout_im;
    logic [4:0]  dout_idx, shift_amt;

    typedef struct {
        int          edge_n;
        logic [22:0] re;
        logic [22:0] im;
    } smp_t;

    typedef struct packed {
        logic [31:0] edge_n;
        logic [10:0] re;
        logic [10:0] im;
        logic [4:0]  idx;
        logic [4:0]  sh;
    } out_t;

    smp_t        sq[$];
    out_t        eq[$];
    out_t        cq[$];
    logic [22:0] blk_re [64];
    logic [22:0] blk_im [64];
    int          cyc = 0;
    int          prev_end = -100;
    int          total = 0;
    int          bad = 0;

    cbfp0_mag_norm dut (
        .clk        (clk),
        .rstn       (rstn),
        .mag_en     (mag_en),
        .din_re     (din_re),
        .din_im     (din_im),
        .dout_valid (dout_valid),
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .dout_idx   (dout_idx),
        .shift_amt  (shift_amt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        out_t o;
        #1;
        if (dout_valid === 1'b1) begin
            o.edge_n = 32'(cyc);
            o.re     = dout_re;
            o.im     = dout_im;
            o.idx    = dout_idx;
            o.sh     = shift_amt;
            cq.push_back(o);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Largest left shift k for which x * 2^k still fits a signed 23-bit word.
    function automatic int lsc_model(input logic [22:0] x);
        longint v;
        longint s;
        v = longint'($signed(x));
        for (int k = 22; k > 0; k--) begin
            s = v * (64'sd1 <<< k);
            if (s >= -(64'sd1 <<< 22) && s < (64'sd1 <<< 22)) return k;
        end
        return 0;
    endfunction

    // Random value that fits in 23-m signed bits, so its LSC is at least m.
    function automatic logic [22:0] rnd_fit(input int m);
        int          half;
        int          v;
        logic [22:0] r;
        half = 1 << (22 - m);
        v    = int'($urandom_range(2 * half - 1, 0)) - half;
        r    = v[22:0];
        return r;
    endfunction

    function automatic void build_expected();
        int     nblk;
        int     m;
        int     start;
        int     close_e;
        longint yr, yi;
        out_t   o;
        nblk = sq.size() / 32;
        for (int b = 0; b < nblk; b++) begin
            m = 22;
            for (int i = 0; i < 32; i++) begin
                if (lsc_model(sq[b*32+i].re) < m) m = lsc_model(sq[b*32+i].re);
                if (lsc_model(sq[b*32+i].im) < m) m = lsc_model(sq[b*32+i].im);
            end
            close_e = sq[b*32+31].edge_n;
            start   = (close_e + 2 > prev_end + 1) ? close_e + 2 : prev_end + 1;
            for (int i = 0; i < 32; i++) begin
                yr       = (longint'($signed(sq[b*32+i].re)) * (64'sd1 <<< m)) >>> 12;
                yi       = (longint'($signed(sq[b*32+i].im)) * (64'sd1 <<< m)) >>> 12;
                o.edge_n = 32'(start + i);
                o.re     = yr[10:0];
                o.im     = yi[10:0];
                o.idx    = 5'(i);
                o.sh     = 5'(m);
                eq.push_back(o);
            end
            prev_end = start + 31;
        end
    endfunction

    task automatic drive(input bit en, input logic [22:0] re, input logic [22:0] im);
        smp_t s;
        mag_en = en;
        din_re = re;
        din_im = im;
        @(posedge clk);
        #1;
        if (en && rstn) begin
            s.edge_n = cyc;
            s.re     = re;
            s.im     = im;
            sq.push_back(s);
        end
        mag_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0);
    endtask

    task automatic send(input int n, input int pause_at, input int pause_len);
        for (int i = 0; i < n; i++) begin
            if (i == pause_at) idle(pause_len);
            drive(1'b1, blk_re[i], blk_im[i]);
        end
    endtask

    task automatic clear_queues();
        sq.delete();
        eq.delete();
        cq.delete();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 23'h1234 + 23'(i), 23'h7ff000);
        total += 5;
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset valid got=%b want=0", dout_valid); end
        if (dout_re !== '0) begin bad++; $display("FAIL reset dout_re got=%h want=0", dout_re); end
        if (dout_im !== '0) begin bad++; $display("FAIL reset dout_im got=%h want=0", dout_im); end
        if (dout_idx !== '0) begin bad++; $display("FAIL reset dout_idx got=%0d want=0", dout_idx); end
        if (shift_amt !== '0) begin bad++; $display("FAIL reset shift got=%0d want=0", shift_amt); end
        rstn = 1'b1;
        clear_queues();
        idle(40);
        total++;
        if (cq.size() != 0) begin bad++; $display("FAIL reset_quiet outputs got=%0d want=0", cq.size()); end
    endtask

    task automatic test_const();
        clear_queues();
        for (int i = 0; i < 32; i++) begin blk_re[i] = 23'h000100; blk_im[i] = 23'h000100; end
        send(32, -1, 0);
        idle(40);
        build_expected();
        total++;
        if (cq.size() != eq.size()) begin bad++; $display("FAIL const count got=%0d want=%0d", cq.size(), eq.size()); end
        foreach (eq[i]) begin
            total++;
            if (i >= cq.size()) begin bad++; $display("FAIL const[%0d] missing want re=%0d", i, $signed(eq[i].re)); end
            else if (cq[i] !== eq[i]) begin
                bad++;
                $display("FAIL const[%0d] got e=%0d re=%0d im=%0d idx=%0d sh=%0d want e=%0d re=%0d im=%0d idx=%0d sh=%0d",
                         i, cq[i].edge_n, $signed(cq[i].re), $signed(cq[i].im), cq[i].idx, cq[i].sh,
                         eq[i].edge_n, $signed(eq[i].re), $signed(eq[i].im), eq[i].idx, eq[i].sh);
            end
        end
        total += 3;
        if (cq.size() > 0 && (cq[0].sh !== 5'd13 || cq[0].re !== 11'd512)) begin
            bad++; $display("FAIL const_abs got sh=%0d re=%0d want sh=13 re=512", cq[0].sh, cq[0].re);
        end
        if (dout_valid !== 1'b0) begin bad++; $display("FAIL const_idle valid got=%b want=0", dout_valid); end
        if (dout_idx !== 5'd31 || dout_re !== 11'd512) begin
            bad++; $display("FAIL const_hold got idx=%0d re=%0d want idx=31 re=512", dout_idx, dout_re);
        end
    endtask

    task automatic test_neg_full_scale();
        int k;
        clear_queues();
        k = int'($urandom_range(31, 0));
        for (int i = 0; i < 32; i++) begin blk_re[i] = rnd_fit(14); blk_im[i] = rnd_fit(14); end
        blk_re[k] = 23'h400000;
        send(32, -1, 0);
        idle(40);
        build_expected();
        total++;
        if (cq.size() != eq.size()) begin bad++; $display("FAIL neg count got=%0d want=%0d", cq.size(), eq.size()); end
        foreach (eq[i]) begin
            total++;
            if (i >= cq.size()) begin bad++; $display("FAIL neg[%0d] missing want re=%0d", i, $signed(eq[i].re)); end
            else if (cq[i] !== eq[i]) begin
                bad++;
                $display("FAIL neg[%0d] got e=%0d re=%0d im=%0d idx=%0d sh=%0d want e=%0d re=%0d im=%0d idx=%0d sh=%0d",
                         i, cq[i].edge_n, $signed(cq[i].re), $signed(cq[i].im), cq[i].idx, cq[i].sh,
                         eq[i].edge_n, $signed(eq[i].re), $signed(eq[i].im), eq[i].idx, eq[i].sh);
            end
        end
        total++;
        if (k < cq.size() && $signed(cq[k].re) !== -11'sd1024) begin
            bad++; $display("FAIL neg_peak got=%0d want=-1024", $signed(cq[k].re));
        end
    endtask

    task automatic test_zero();
        clear_queues();
        for (int i = 0; i < 32; i++) begin blk_re[i] = '0; blk_im[i] = '0; end
        send(32, -1, 0);
        idle(40);
        build_expected();
        total++;
        if (cq.size() != eq.size()) begin bad++; $display("FAIL zero count got=%0d want=%0d", cq.size(), eq.size()); end
        foreach (eq[i]) begin
            total++;
            if (i >= cq.size()) begin bad++; $display("FAIL zero[%0d] missing", i); end
            else if (cq[i] !== eq[i] || cq[i].sh !== 5'd22) begin
                bad++;
                $display("FAIL zero[%0d] got e=%0d re=%0d im=%0d sh=%0d want e=%0d re=0 im=0 sh=22",
                         i, cq[i].edge_n, $signed(cq[i].re), $signed(cq[i].im), cq[i].sh, eq[i].edge_n);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ka, kb;
        clear_queues();
        ka = int'($urandom_range(31, 0));
        kb = int'($urandom_range(31, 0));
        for (int i = 0; i < 32; i++) begin
            blk_re[i] = rnd_fit(13); blk_im[i] = rnd_fit(13);
            blk_re[32+i] = rnd_fit(2); blk_im[32+i] = rnd_fit(2);
        end
        blk_im[ka]    = 23'd511;
        blk_re[32+kb] = 23'h700000;
        send(64, -1, 0);
        idle(40);
        build_expected();
        total++;
        if (cq.size() != eq.size()) begin bad++; $display("FAIL b2b count got=%0d want=%0d", cq.size(), eq.size()); end
        foreach (eq[i]) begin
            total++;
            if (i >= cq.size()) begin bad++; $display("FAIL b2b[%0d] missing want e=%0d", i, eq[i].edge_n); end
            else if (cq[i] !== eq[i]) begin
                bad++;
                $display("FAIL b2b[%0d] got e=%0d re=%0d im=%0d idx=%0d sh=%0d want e=%0d re=%0d im=%0d idx=%0d sh=%0d",
                         i, cq[i].edge_n, $signed(cq[i].re), $signed(cq[i].im), cq[i].idx, cq[i].sh,
                         eq[i].edge_n, $signed(eq[i].re), $signed(eq[i].im), eq[i].idx, eq[i].sh);
            end
        end
        total++;
        if (cq.size() == 64 && (cq[0].sh !== 5'd13 || cq[32].sh !== 5'd2 || cq[63].edge_n - cq[0].edge_n !== 32'd63)) begin
            bad++; $display("FAIL b2b_shape got sh=%0d/%0d span=%0d want 13/2 span=63",
                            cq[0].sh, cq[32].sh, cq[63].edge_n - cq[0].edge_n);
        end
    endtask

    task automatic test_pause();
        clear_queues();
        for (int i = 0; i < 32; i++) begin blk_re[i] = rnd_fit(6); blk_im[i] = rnd_fit(9); end
        send(32, 16, 5);
        idle(40);
        build_expected();
        total++;
        if (cq.size() != eq.size()) begin bad++; $display("FAIL pause count got=%0d want=%0d", cq.size(), eq.size()); end
        foreach (eq[i]) begin
            total++;
            if (i >= cq.size()) begin bad++; $display("FAIL pause[%0d] missing want e=%0d", i, eq[i].edge_n); end
            else if (cq[i] !== eq[i]) begin
                bad++;
                $display("FAIL pause[%0d] got e=%0d re=%0d im=%0d idx=%0d sh=%0d want e=%0d re=%0d im=%0d idx=%0d sh=%0d",
                         i, cq[i].edge_n, $signed(cq[i].re), $signed(cq[i].im), cq[i].idx, cq[i].sh,
                         eq[i].edge_n, $signed(eq[i].re), $signed(eq[i].im), eq[i].idx, eq[i].sh);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        bit found;
        int n_pre;
        clear_queues();
        for (int i = 0; i < 32; i++) begin blk_re[i] = rnd_fit(4); blk_im[i] = rnd_fit(4); end
        send(32, -1, 0);
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            if (dout_valid === 1'b1 && dout_idx === 5'd10) found = 1'b1;
            else idle(1);
        end
        total++;
        if (!found) begin bad++; $display("FAIL rst_mid reach idx10 got=none want=idx10"); end
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        prev_end = -100;
        total++;
        if (dout_valid !== 1'b0 || dout_idx !== '0 || dout_re !== '0) begin
            bad++; $display("FAIL rst_mid outputs got v=%b idx=%0d re=%0d want 0/0/0", dout_valid, dout_idx, dout_re);
        end
        n_pre = cq.size();
        idle(40);
        total++;
        if (cq.size() != n_pre) begin bad++; $display("FAIL rst_mid residue got=%0d want=0", cq.size() - n_pre); end
        clear_queues();
        for (int i = 0; i < 32; i++) begin blk_re[i] = rnd_fit(11); blk_im[i] = rnd_fit(8); end
        send(32, -1, 0);
        idle(40);
        build_expected();
        total++;
        if (cq.size() != eq.size()) begin bad++; $display("FAIL rst_after count got=%0d want=%0d", cq.size(), eq.size()); end
        foreach (eq[i]) begin
            total++;
            if (i >= cq.size()) begin bad++; $display("FAIL rst_after[%0d] missing", i); end
            else if (cq[i] !== eq[i]) begin
                bad++;
                $display("FAIL rst_after[%0d] got e=%0d re=%0d im=%0d idx=%0d sh=%0d want e=%0d re=%0d im=%0d idx=%0d sh=%0d",
                         i, cq[i].edge_n, $signed(cq[i].re), $signed(cq[i].im), cq[i].idx, cq[i].sh,
                         eq[i].edge_n, $signed(eq[i].re), $signed(eq[i].im), eq[i].idx, eq[i].sh);
            end
        end
    endtask

    task automatic test_random();
        int ma, mb;
        for (int r = 0; r < 4; r++) begin
            clear_queues();
            ma = int'($urandom_range(22, 0));
            mb = int'($urandom_range(22, 0));
            for (int i = 0; i < 32; i++) begin
                blk_re[i] = rnd_fit(ma); blk_im[i] = rnd_fit(ma);
                blk_re[32+i] = rnd_fit(mb); blk_im[32+i] = rnd_fit(mb);
            end
            send(64, int'($urandom_range(63, 1)), int'($urandom_range(4, 0)));
            idle(40);
            build_expected();
            total++;
            if (cq.size() != eq.size()) begin bad++; $display("FAIL rand%0d count got=%0d want=%0d", r, cq.size(), eq.size()); end
            foreach (eq[i]) begin
                total++;
                if (i >= cq.size()) begin bad++; $display("FAIL rand%0d[%0d] missing", r, i); end
                else if (cq[i] !== eq[i]) begin
                    bad++;
                    $display("FAIL rand%0d[%0d] got e=%0d re=%0d im=%0d idx=%0d sh=%0d want e=%0d re=%0d im=%0d idx=%0d sh=%0d",
                             r, i, cq[i].edge_n, $signed(cq[i].re), $signed(cq[i].im), cq[i].idx, cq[i].sh,
                             eq[i].edge_n, $signed(eq[i].re), $signed(eq[i].im), eq[i].idx, eq[i].sh);
                end
            end
        end
    endtask

    initial begin
        rstn   = 1'b0;
        mag_en = 1'b0;
        din_re = '0;
        din_im = '0;
        test_reset();
        test_const();
        test_neg_full_scale();
        test_zero();
        test_back_to_back();
        test_pause();
        test_reset_mid_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
